// File: rtl/core_pkg.sv
// Shared writeback-path constants and the request record used by the
// register-file write arbiter.
package core_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int RF_DEPTH = 32;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant that scans from the
// rotating pointer, plus the pointer register itself.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    output logic [N-1:0]         gnt_o,
    output logic                 any_o,
    output logic [$clog2(N)-1:0] idx_o
);

    localparam int PW = $clog2(N);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] idx;
    logic          found;

    // Nothing is granted while reset is held, so no request is consumed.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx_o = '0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr_q) + k) % N);
            if (!found && !rst_i && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
                idx_o      = idx;
            end
        end
        any_o = found;
    end

    assign ptr_d = (idx_o == PW'(N - 1)) ? '0 : idx_o + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (any_o) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write port sharing: round-robin pick among writeback sources,
// one-entry writeback stage, x0 filtering and a forwarding lookup for decode.
module rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int REG_AW  = 5
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*REG_AW-1:0] req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [REG_AW-1:0]         rf_wr_reg_o,
    output logic [XLEN-1:0]           rf_wr_data_o,
    output logic                      rf_wr_en_o,
    input  logic [REG_AW-1:0]         fwd_rs1_i,
    input  logic [REG_AW-1:0]         fwd_rs2_i,
    output logic                      fwd_hit1_o,
    output logic                      fwd_hit2_o,
    output logic [XLEN-1:0]           fwd_data1_o,
    output logic [XLEN-1:0]           fwd_data2_o
);

    import core_pkg::*;

    logic [NUM_REQ-1:0]         gnt;
    logic                       gnt_any;
    logic [$clog2(NUM_REQ)-1:0] win;

    logic                       vld_q, vld_d;
    logic [REG_AW-1:0]          rd_q, rd_d;
    logic [XLEN-1:0]            data_q, data_d;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_valid_i),
        .gnt_o (gnt),
        .any_o (gnt_any),
        .idx_o (win)
    );

    assign req_ready_o = gnt;

    // x0 writes still complete the handshake but never reach the array.
    always_comb begin
        rd_d   = rd_q;
        data_d = data_q;
        vld_d  = 1'b0;
        if (gnt_any) begin
            rd_d   = req_rd_i[int'(win)*REG_AW +: REG_AW];
            data_d = req_data_i[int'(win)*XLEN +: XLEN];
            vld_d  = (rd_d != '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign rf_wr_en_o   = vld_q;
    assign rf_wr_reg_o  = rd_q;
    assign rf_wr_data_o = data_q;

    assign fwd_hit1_o  = vld_q && (fwd_rs1_i == rd_q) && (fwd_rs1_i != '0);
    assign fwd_hit2_o  = vld_q && (fwd_rs2_i == rd_q) && (fwd_rs2_i != '0);
    assign fwd_data1_o = fwd_hit1_o ? data_q : '0;
    assign fwd_data2_o = fwd_hit2_o ? data_q : '0;

endmodule
